// File: rtl/answer_pkg.sv
// answer_pkg
// Shared definitions for the quiz answer controller: FSM state encoding,
// score ceiling, BCD digit widths and the saturating score helpers.
// No ports; imported by answer_ctrl_if, bcd_down_timer and answer_ctrl.
package answer_pkg;

    // Game states as seen on state_o
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_OPEN   = 2'd2;
    localparam logic [1:0] ST_ANSWER = 2'd3;

    // Default score ceiling and score register width
    localparam int SCORE_MAX = 99;
    localparam int SCORE_W   = 8;

    // BCD digit widths of the countdown (tens 0..5, units 0..9)
    localparam int TENS_W = 3;
    localparam int UNIT_W = 4;

    // Score operation requested by the FSM for the current cycle
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;

    // Add points, clamping at cap
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] s,
        input logic [3:0]         a,
        input logic [SCORE_W-1:0] cap
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(a);
        return (sum >= {1'b0, cap}) ? cap : sum[SCORE_W-1:0];
    endfunction

    // Deduct points, clamping at zero
    function automatic logic [SCORE_W-1:0] sat_sub(
        input logic [SCORE_W-1:0] s,
        input logic [3:0]         d
    );
        return (s < SCORE_W'(d)) ? '0 : s - SCORE_W'(d);
    endfunction

endpackage

// File: rtl/answer_ctrl_if.sv
// answer_ctrl_if
// Bundles everything between the host/settings logic and answer_ctrl
// except clock and reset.
//   master : drives start, cfg_*, tick, buzz, open_q, judge_ok, judge_bad;
//            receives state_o, winner, time_tens, time_unit, score
//   slave  : the opposite view, used by answer_ctrl
interface answer_ctrl_if
    import answer_pkg::*;
#(
    parameter int NP = 4
);
    logic                  start;
    logic [2:0]            cfg_player;
    logic [TENS_W-1:0]     cfg_time_tens;
    logic [UNIT_W-1:0]     cfg_time_unit;
    logic [3:0]            cfg_add;
    logic [3:0]            cfg_sub;
    logic                  tick;
    logic [NP-1:0]         buzz;
    logic                  open_q;
    logic                  judge_ok;
    logic                  judge_bad;

    logic [1:0]            state_o;
    logic [2:0]            winner;
    logic [TENS_W-1:0]     time_tens;
    logic [UNIT_W-1:0]     time_unit;
    logic [SCORE_W*NP-1:0] score;

    modport master (
        output start, cfg_player, cfg_time_tens, cfg_time_unit, cfg_add, cfg_sub,
               tick, buzz, open_q, judge_ok, judge_bad,
        input  state_o, winner, time_tens, time_unit, score
    );

    modport slave (
        input  start, cfg_player, cfg_time_tens, cfg_time_unit, cfg_add, cfg_sub,
               tick, buzz, open_q, judge_ok, judge_bad,
        output state_o, winner, time_tens, time_unit, score
    );
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
// Two-digit BCD seconds countdown.
//   clk, rst              : clock, async active-low reset (digits -> 00)
//   load, load_tens/unit  : load a new value (wins over decrement)
//   dec                   : decrement one second this cycle
//   tens, unit            : current value
//   expire                : one-cycle pulse on the decrement taking 01 to 00
module bcd_down_timer
    import answer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TENS_W-1:0] load_tens,
    input  logic [UNIT_W-1:0] load_unit,
    input  logic              dec,
    output logic [TENS_W-1:0] tens,
    output logic [UNIT_W-1:0] unit,
    output logic              expire
);

    logic at_zero;

    assign at_zero = (tens == '0) && (unit == '0);
    assign expire  = dec && !load && (tens == '0) && (unit == UNIT_W'(1));

    // Units wrap 0 -> 9 borrowing from tens; a timer at 00 stays there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            unit <= '0;
        end else if (load) begin
            tens <= load_tens;
            unit <= load_unit;
        end else if (dec && !at_zero) begin
            if (unit == '0) begin
                unit <= UNIT_W'(9);
                tens <= tens - TENS_W'(1);
            end else begin
                unit <= unit - UNIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/answer_ctrl.sv
// answer_ctrl
// Quiz-show answer controller: arms the buzzers, picks the first player,
// counts down the answer time and applies host judgements to the scores.
//   clk  : system clock
//   rst  : async active-low reset
//   bus  : answer_ctrl_if.slave -- settings, tick, buttons in;
//          state_o, winner, remaining time and packed scores out
module answer_ctrl
    import answer_pkg::*;
#(
    parameter int NP        = 4,
    parameter int SCORE_MAX = answer_pkg::SCORE_MAX
)(
    input  logic          clk,
    input  logic          rst,
    answer_ctrl_if.slave  bus
);

    localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

    // Edge-detector history and arming flag
    logic          start_q, open_q_q, ok_q, bad_q, armed;
    logic [NP-1:0] buzz_q;
    logic          start_edge, open_edge, ok_edge, bad_edge;
    logic [NP-1:0] buzz_edge;

    // Latched game configuration
    logic [2:0]        players_q;
    logic [TENS_W-1:0] tens_q;
    logic [UNIT_W-1:0] unit_q;
    logic [3:0]        add_q, sub_q;
    logic [2:0]        eff_players;
    logic [UNIT_W-1:0] eff_unit;

    // FSM, winner, scores
    logic [1:0]         state, state_nx;
    logic [2:0]         winner, winner_nx;
    logic [1:0]         score_op;
    logic               timer_load, timer_dec, expire;
    logic [NP-1:0]      buzz_ok;
    logic               buzz_hit;
    logic [2:0]         buzz_id;
    logic [SCORE_W-1:0] scores [NP];

    // armed stays low for the first cycle after reset so the history
    // registers pick up any buttons held through reset before edges count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q  <= 1'b0;
            open_q_q <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            buzz_q   <= '0;
            armed    <= 1'b0;
        end else begin
            start_q  <= bus.start;
            open_q_q <= bus.open_q;
            ok_q     <= bus.judge_ok;
            bad_q    <= bus.judge_bad;
            buzz_q   <= bus.buzz;
            armed    <= 1'b1;
        end
    end

    assign start_edge = armed & bus.start     & ~start_q;
    assign open_edge  = armed & bus.open_q    & ~open_q_q;
    assign ok_edge    = armed & bus.judge_ok  & ~ok_q;
    assign bad_edge   = armed & bus.judge_bad & ~bad_q;
    assign buzz_edge  = {NP{armed}} & bus.buzz & ~buzz_q;

    // Clamp the configured player count to 1..NP and the time to >= 01
    always_comb begin
        eff_players = bus.cfg_player;
        if (bus.cfg_player == 3'd0)
            eff_players = 3'd1;
        else if (int'(bus.cfg_player) > NP)
            eff_players = 3'(NP);
        eff_unit = bus.cfg_time_unit;
        if (bus.cfg_time_tens == '0 && bus.cfg_time_unit == '0)
            eff_unit = UNIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            players_q <= 3'd1;
            tens_q    <= '0;
            unit_q    <= UNIT_W'(1);
            add_q     <= '0;
            sub_q     <= '0;
        end else if (start_edge) begin
            players_q <= eff_players;
            tens_q    <= bus.cfg_time_tens;
            unit_q    <= eff_unit;
            add_q     <= bus.cfg_add;
            sub_q     <= bus.cfg_sub;
        end
    end

    // Lowest enabled index wins a same-cycle tie: scan from the top down
    always_comb begin
        buzz_hit = 1'b0;
        buzz_id  = 3'd0;
        for (int i = 0; i < NP; i++)
            buzz_ok[i] = buzz_edge[i] && (3'(i) < players_q);
        for (int i = NP - 1; i >= 0; i--) begin
            if (buzz_ok[i]) begin
                buzz_hit = 1'b1;
                buzz_id  = 3'(i + 1);
            end
        end
    end

    assign timer_dec = bus.tick && (state == ST_OPEN || state == ST_ANSWER);

    bcd_down_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_tens (tens_q),
        .load_unit (unit_q),
        .dec       (timer_dec),
        .tens      (bus.time_tens),
        .unit      (bus.time_unit),
        .expire    (expire)
    );

    // Next-state logic; a start edge restarts the game from any state.
    // Coinciding ok/bad edges cancel each other, leaving only expiry.
    always_comb begin
        state_nx   = state;
        winner_nx  = winner;
        timer_load = 1'b0;
        score_op   = OP_NONE;
        if (start_edge) begin
            state_nx  = ST_READY;
            winner_nx = 3'd0;
        end else begin
            case (state)
                ST_READY: begin
                    if (open_edge) begin
                        state_nx   = ST_OPEN;
                        timer_load = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (buzz_hit) begin
                        state_nx   = ST_ANSWER;
                        winner_nx  = buzz_id;
                        timer_load = 1'b1;
                    end else if (expire) begin
                        state_nx  = ST_READY;
                        winner_nx = 3'd0;
                    end
                end
                ST_ANSWER: begin
                    if (ok_edge && !bad_edge) begin
                        score_op  = OP_ADD;
                        state_nx  = ST_READY;
                        winner_nx = 3'd0;
                    end else if ((bad_edge && !ok_edge) || expire) begin
                        score_op  = OP_SUB;
                        state_nx  = ST_READY;
                        winner_nx = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            winner <= 3'd0;
        end else begin
            state  <= state_nx;
            winner <= winner_nx;
        end
    end

    // Score registers; only the current winner's entry is touched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NP; i++)
                scores[i] <= '0;
        end else if (start_edge) begin
            for (int i = 0; i < NP; i++)
                scores[i] <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (3'(i + 1) == winner) begin
                    if (score_op == OP_ADD)
                        scores[i] <= sat_add(scores[i], add_q, SCORE_CAP);
                    else if (score_op == OP_SUB)
                        scores[i] <= sat_sub(scores[i], sub_q);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++)
            bus.score[SCORE_W*i +: SCORE_W] = scores[i];
    end

    assign bus.state_o = state;
    assign bus.winner  = winner;

endmodule

// File: doc/answer_ctrl.md
ANSWER_CTRL -- requirements
Module: answer_ctrl

Interface
REQ-001 Parameter NP, default 4: number of physical buzzer inputs.
REQ-002 Parameter SCORE_MAX, default 99: score saturation ceiling.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  level from the settings stage `finish`; its rising edge begins a game.
REQ-006 cfg_player  in  3  configured player count.
REQ-007 cfg_time_tens  in  3  answer-time tens digit, 0..5.
REQ-008 cfg_time_unit  in  4  answer-time units digit, 0..9.
REQ-009 cfg_add  in  4  points awarded for a correct answer.
REQ-010 cfg_sub  in  4  points deducted for a wrong answer or timeout.
REQ-011 tick  in  1  one-cycle pulse once per second.
REQ-012 buzz  in  NP  debounced player buttons, active-high levels.
REQ-013 open_q, judge_ok, judge_bad  in  1 each  debounced host buttons, active-high levels.
REQ-014 state_o  out  2  current state.
REQ-015 winner  out  3  buzzing player, 1..NP; 0 = none.
REQ-016 time_tens / time_unit  out  3 / 4  remaining seconds, BCD.
REQ-017 score  out  8*NP  per-player scores, packed; player 1 in bits [7:0].

Function
REQ-018 All button inputs, including start, SHALL be rising-edge detected internally; each press acts exactly once.
REQ-019 On the start edge, the block SHALL latch all cfg_* inputs, clear scores, and go to READY.
- cfg_player 0 is treated as 1; values >NP are treated as NP.
- A configured time of 00 is treated as 01.
REQ-020 States SHALL be IDLE(0), READY(1), OPEN(2), ANSWER(3).
- IDLE --start--> READY.
- READY --open_q--> OPEN: load timer with configured time.
REQ-021 In OPEN, on the first enabled buzz edge:
- record the winner;
- reload the timer;
- go to ANSWER in the same cycle.
- If several players buzz in the same cycle, the lowest index wins.
- Buzzes from players above the latched count are ignored.
REQ-022 In OPEN, timer expiry SHALL return to READY with no score change and winner=0.
REQ-023 In ANSWER, judge_ok edge: winner score += cfg_add, saturating at SCORE_MAX; go to READY.
REQ-024 In ANSWER, judge_bad edge or timer expiry: winner score -= cfg_sub, saturating at 0; go to READY.
REQ-025 If judge_ok and judge_bad edges coincide, both SHALL be ignored for that cycle.
REQ-026 Score updates SHALL be registered; the new score is visible the cycle after the judging edge.
REQ-027 The timer SHALL decrement by one BCD second per tick, in OPEN and ANSWER only.
- Units wrap from 0 to 9 and borrow from tens.
- Expiry occurs on the tick that takes the timer from 01 to 00.
REQ-028 Buzz edges outside OPEN, and host edges outside their owning state, SHALL be ignored.
REQ-029 A start edge in any non-IDLE state SHALL restart the game exactly as in REQ-019.
REQ-030 winner SHALL hold its value through ANSWER and clear on entry to READY.

Reset
REQ-031 While rst=0, outputs SHALL be: state_o=IDLE, winner=0, time digits=0, all scores=0.
REQ-032 On reset, all edge-detector history SHALL be cleared so that held buttons do not fire when rst is released.
REQ-033 Reset asserted mid-OPEN or mid-ANSWER SHALL abort the round and make no score update.

Structure
REQ-034 Shared package answer_pkg SHALL hold:
- state encoding;
- SCORE_MAX;
- BCD digit width constants.
REQ-035 Sub-module bcd_down_timer SHALL provide load, tick-decrement, and expire pulse; it is instantiated once.

Verification
REQ-036 Reset/start: rst=0, then release with buzz held high → no event fires. Then start edge with cfg 4 players, 15 s, add 3, sub 2 → state READY, scores 0.
REQ-037 Correct answer: open_q, buzz[2] edge → winner=3, time 15. judge_ok → score3=3 on the next cycle, state READY.
REQ-038 Tie and disabled player, with cfg_player=2: buzz[0] and buzz[1] in the same cycle → winner=1. Separately, buzz[3] alone → ignored, state stays OPEN.
REQ-039 Timeouts with time 02: in OPEN, 2 ticks → READY with no score change. In ANSWER, 2 ticks → winner score -2, floored at 0.
REQ-040 Saturation:
- 40 correct answers with add=3 → score holds at 99.
- judge_ok and judge_bad in the same cycle → no change.
- start mid-ANSWER → scores cleared, state READY.
